router_port_ctrl: RTL and testbench

Input-side port controller for the 1x3 router, sitting between the router FSM and the three output FIFOs.
- Latches the destination address on the header byte.
- Steers the FSM's write enable to the addressed FIFO and returns that FIFO's full flag to the FSM.
- Drives per-port valid_out.
- Runs per-port read-timeout counters that issue soft resets, which flush a FIFO whose reader has stalled.

---
 rtl/router_port_ctrl.sv | 113 +++++++++++
 tb/tb_router_port_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/router_port_ctrl.sv
// router_port_ctrl
//   Input-side port controller for the 1x3 router. It sits between the
//   router FSM and the three output FIFOs:
//     - latches the destination address from the header byte,
//     - steers the FSM write enable to the addressed FIFO and returns
//       that FIFO's full flag,
//     - drives per-port valid to the output readers,
//     - runs per-port read-timeout counters that pulse a soft reset to
//       flush a FIFO whose reader has stalled.
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-low
//   detect_add  FSM in address-decode state; din is latched this cycle
//   din[1:0]    address field of the header byte (2'b11 = invalid)
//   we_en_reg   FSM write request for the current packet
//   rd_en[2:0]  per-port read enable from the output readers
//   fifoe[2:0]  per-port FIFO empty flags
//   fifof[2:0]  per-port FIFO full flags
//   we_en[2:0]  one-hot FIFO write enable
//   fifofull    full flag of the addressed FIFO
//   vld_out[2:0] per-port data valid to the output readers
//   srst[2:0]   per-port soft reset, one-cycle pulse
//
// Optional feature, macro ROUTER_TO_STATUS_EN:
//   adds input to_clr and output to_sts[2:0], a sticky record of which
//   ports have timed out. to_clr clears it; a new timeout wins over clear.
//
// Reader handshake: port n offers data while vld_out[n]=1; the reader
// consumes one entry at each clk edge where vld_out[n] and rd_en[n] are
// both high. Any cycle with vld_out[n]=1 and rd_en[n]=0 is a stall.

module router_port_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       detect_add,
  input  logic [1:0] din,
  input  logic       we_en_reg,
  input  logic [2:0] rd_en,
  input  logic [2:0] fifoe,
  input  logic [2:0] fifof,
`ifdef ROUTER_TO_STATUS_EN
  input  logic       to_clr,
  output logic [2:0] to_sts,
`endif
  output logic [2:0] we_en,
  output logic       fifofull,
  output logic [2:0] vld_out,
  output logic [2:0] srst
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       port_sel;
  logic [CNT_W-1:0] cnt     [3];
  logic [CNT_W-1:0] cnt_nxt [3];
  logic [2:0]       srst_nxt;

  assign vld_out = ~fifoe;

  // port_sel = 3 means no port selected: writes are dropped, full reads 0.
  always_comb begin
    we_en    = 3'b000;
    fifofull = 1'b0;
    case (port_sel)
      2'd0: begin we_en[0] = we_en_reg; fifofull = fifof[0]; end
      2'd1: begin we_en[1] = we_en_reg; fifofull = fifof[1]; end
      2'd2: begin we_en[2] = we_en_reg; fifofull = fifof[2]; end
      default: begin we_en = 3'b000; fifofull = 1'b0; end
    endcase
  end

  // Timeout counters. The cycle in which srst is high is the flush cycle
  // and is never counted, so a continuing stall restarts from zero.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      cnt_nxt[n]  = '0;
      srst_nxt[n] = 1'b0;
      if (srst[n]) begin
        cnt_nxt[n] = '0;
      end else if (!vld_out[n] || rd_en[n]) begin
        cnt_nxt[n] = '0;
      end else if (cnt[n] == CNT_LAST) begin
        srst_nxt[n] = 1'b1;
      end else begin
        cnt_nxt[n] = cnt[n] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      port_sel <= 2'b11;
      srst     <= 3'b000;
      for (int n = 0; n < 3; n++) cnt[n] <= '0;
    end else begin
      if (detect_add) port_sel <= din;
      srst <= srst_nxt;
      for (int n = 0; n < 3; n++) cnt[n] <= cnt_nxt[n];
    end
  end

`ifdef ROUTER_TO_STATUS_EN
  always_ff @(posedge clk) begin
    if (!rst) to_sts <= 3'b000;
    else      to_sts <= (to_clr ? 3'b000 : to_sts) | srst_nxt;
  end
`endif

endmodule

// File: tb/tb_router_port_ctrl.sv
// Bench for router_port_ctrl: reset check, table-driven steering vectors,
// and hand-written timeout sequences with a queue of expected srst values.

module tb_router_port_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       detect_add;
  logic [1:0] din;
  logic       we_en_reg;
  logic [2:0] rd_en;
  logic [2:0] fifoe;
  logic [2:0] fifof;
  logic [2:0] we_en;
  logic       fifofull;
  logic [2:0] vld_out;
  logic [2:0] srst;
`ifdef ROUTER_TO_STATUS_EN
  logic       to_clr = 1'b0;
  logic [2:0] to_sts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] exp_q[$];   // {we_en, fifofull, vld_out}
  logic [2:0] srst_q[$];  // expected srst after each edge

  router_port_ctrl #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .detect_add(detect_add), .din(din),
    .we_en_reg(we_en_reg), .rd_en(rd_en), .fifoe(fifoe), .fifof(fifof),
`ifdef ROUTER_TO_STATUS_EN
    .to_clr(to_clr), .to_sts(to_sts),
`endif
    .we_en(we_en), .fifofull(fifofull), .vld_out(vld_out), .srst(srst)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic       da;
    logic [1:0] din;
    logic       wer;
    logic [2:0] fifof;
    logic [2:0] fifoe;
    logic [2:0] exp_we;
    logic       exp_ff;
    logic [2:0] exp_vld;
  } vec_t;

  vec_t vecs[11];

  task automatic check7(input string name, input logic [6:0] got);
    logic [6:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got we_en/fifofull/vld_out=%b expected %b", name, got, exp);
    end
  endtask

  task automatic check3(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // One clock cycle of timeout stimulus; called just after a negedge.
  task automatic step(input string name, input logic [2:0] fe, input logic [2:0] rd,
                      input logic rv, input logic [2:0] exp_srst);
    logic [2:0] e;
    fifoe = fe; rd_en = rd; rst = rv;
    #1;
    check3({name, "_vld"}, vld_out, ~fe);
    @(posedge clk);
    srst_q.push_back(exp_srst);
    @(negedge clk);
    e = srst_q.pop_front();
    check3(name, srst, e);
  endtask

  initial begin
    // row: da din wer fifof fifoe | we_en fifofull vld_out
    vecs[0]  = '{1'b1, 2'b01, 1'b1, 3'b010, 3'b111, 3'b000, 1'b0, 3'b000};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b110, 3'b010, 1'b1, 3'b001};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 3'b111};
    vecs[3]  = '{1'b1, 2'b10, 1'b1, 3'b101, 3'b101, 3'b010, 1'b0, 3'b010};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 3'b000, 3'b011, 3'b100, 1'b0, 3'b100};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 3'b100, 3'b111, 3'b100, 1'b1, 3'b000};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 3'b111, 3'b111, 3'b000, 1'b1, 3'b000};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000};
    vecs[8]  = '{1'b1, 2'b11, 1'b1, 3'b111, 3'b111, 3'b001, 1'b1, 3'b000};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
    vecs[10] = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 3'b111};

    // reset for two cycles with all FIFOs empty
    rst = 1'b0; detect_add = 1'b0; din = 2'b00; we_en_reg = 1'b1;
    rd_en = 3'b000; fifoe = 3'b111; fifof = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check3("rst_we_en", we_en, 3'b000);
    check3("rst_fifofull", {2'b00, fifofull}, 3'b000);
    check3("rst_srst", srst, 3'b000);
    check3("rst_vld_out", vld_out, 3'b000);
    rst = 1'b1;

    // steering vectors; readers keep reading so counters stay idle
    rd_en = 3'b111;
    for (int i = 0; i < 11; i++) begin
      detect_add = vecs[i].da; din = vecs[i].din; we_en_reg = vecs[i].wer;
      fifof = vecs[i].fifof; fifoe = vecs[i].fifoe;
      exp_q.push_back({vecs[i].exp_we, vecs[i].exp_ff, vecs[i].exp_vld});
      #1;
      check7($sformatf("vec%0d", i), {we_en, fifofull, vld_out});
      @(negedge clk);
    end
    detect_add = 1'b0; we_en_reg = 1'b0;
    step("idle", 3'b111, 3'b000, 1'b1, 3'b000);

    // port 0 timeout, then continued stall restarts the count
    for (int i = 1; i <= 61; i++)
      step($sformatf("to0_c%0d", i), 3'b110, 3'b000, 1'b1,
           (i == 30 || i == 61) ? 3'b001 : 3'b000);
    step("to0_end", 3'b111, 3'b000, 1'b1, 3'b000);

    // port 1 stall interrupted by a single read
    for (int i = 1; i <= 29; i++)
      step($sformatf("to1a_c%0d", i), 3'b101, 3'b000, 1'b1, 3'b000);
    step("to1_read", 3'b101, 3'b010, 1'b1, 3'b000);
    for (int i = 1; i <= 30; i++)
      step($sformatf("to1b_c%0d", i), 3'b101, 3'b000, 1'b1,
           (i == 30) ? 3'b010 : 3'b000);
    step("to1_end", 3'b111, 3'b000, 1'b1, 3'b000);

    // ports 0 and 2 time out together
    for (int i = 1; i <= 30; i++)
      step($sformatf("to02_c%0d", i), 3'b010, 3'b000, 1'b1,
           (i == 30) ? 3'b101 : 3'b000);
    step("to02_end", 3'b111, 3'b000, 1'b1, 3'b000);

    // reset at stalled cycle 20, then the count restarts from zero
    for (int i = 1; i <= 19; i++)
      step($sformatf("rs_c%0d", i), 3'b010, 3'b000, 1'b1, 3'b000);
    step("rs_reset", 3'b010, 3'b000, 1'b0, 3'b000);
    for (int i = 1; i <= 30; i++)
      step($sformatf("rs_after_c%0d", i), 3'b010, 3'b000, 1'b1,
           (i == 30) ? 3'b101 : 3'b000);
    step("rs_end", 3'b111, 3'b000, 1'b1, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
